mem_arbiter: RTL and testbench

Shares the single 32-bit asynchronous SRAM port between the instruction fetch path (IF) and the data path (MEM stage, driven by the EX outputs result/mem_data/if_mem_read/if_mem_write/load_byte). It sequences each access as a multi-cycle SRAM cycle and handles byte lanes for LB/SB. MEM has strict priority over IF. The pipeline stalls on the req/done handshake instead of fixed bubble counts.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_byte_lane.sv | 39 +++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding, byte-lane
// constants and the legal strobe-length range.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_ERR
   } arb_state_t;

   localparam logic [1:0] LANE0 = 2'd0;
   localparam logic [1:0] LANE1 = 2'd1;
   localparam logic [1:0] LANE2 = 2'd2;
   localparam logic [1:0] LANE3 = 2'd3;

   localparam int WAIT_MIN = 2;
   localparam int WAIT_MAX = 7;
   localparam int CNT_W    = 3;

endpackage

// File: rtl/mem_byte_lane.sv
// Little-endian byte-lane steering: byte enables and replicated store data
// on the way out, lane extraction with sign extension on the way in.
module mem_byte_lane
   import mem_arbiter_pkg::*;
(
   input  logic [1:0]  lane,
   input  logic        is_byte,
   input  logic        is_write,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be_n,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic [7:0] sel_byte;

   always_comb begin
      sel_byte  = rdata[7:0];
      be_n      = 4'h0;
      wdata_rep = wdata;
      rdata_ext = rdata;
      case (lane)
         LANE0:   sel_byte = rdata[7:0];
         LANE1:   sel_byte = rdata[15:8];
         LANE2:   sel_byte = rdata[23:16];
         default: sel_byte = rdata[31:24];
      endcase
      // Only byte stores narrow the enables; byte loads read the whole word.
      if (is_byte && is_write) begin
         be_n = ~(4'b0001 << lane);
      end
      if (is_byte) begin
         wdata_rep = {4{wdata[7:0]}};
         rdata_ext = {{24{sel_byte[7]}}, sel_byte};
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one asynchronous SRAM port between instruction fetch and the
// data path; MEM has strict priority and each access is a timed strobe cycle.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_done,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic              mem_byte,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_done,
   output logic              mem_err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic              ram_ce_n,
   output logic              ram_oe_n,
   output logic              ram_we_n,
   output logic [3:0]        ram_be_n,
   output logic              busy
);

   localparam int WAIT_EFF = (WAIT_CYCLES < WAIT_MIN) ? WAIT_MIN :
                             (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);

   arb_state_t       state, state_next;
   logic [CNT_W-1:0] cnt;
   logic             sel_mem, acc_we, acc_byte;
   logic [1:0]       acc_lane;
   logic             mem_elig, if_elig, mem_misaligned;
   logic             start_mem, start_if;
   logic [1:0]       lane_sel;
   logic             lane_byte, lane_write;
   logic [31:0]      lane_wdata_in;
   logic [3:0]       lane_be_n;
   logic [31:0]      lane_wdata, lane_rdata;
   logic             unused_addr_bits;

   // A requester whose done is high this cycle is withdrawing, not asking again.
   assign mem_elig       = mem_req && !mem_done;
   assign if_elig        = if_req && !if_done;
   assign mem_misaligned = !mem_byte && (mem_addr[1:0] != 2'b00);
   assign busy           = (state != ST_IDLE);
   assign unused_addr_bits = ^{if_addr[1:0], if_addr[31:ADDR_W+2], mem_addr[31:ADDR_W+2]};

   // In IDLE the lane logic looks at the incoming request, otherwise at the latched one.
   assign lane_sel      = (state == ST_IDLE) ? mem_addr[1:0] : acc_lane;
   assign lane_byte     = (state == ST_IDLE) ? mem_byte      : acc_byte;
   assign lane_write    = (state == ST_IDLE) ? mem_we        : acc_we;
   assign lane_wdata_in = mem_wdata;

   mem_byte_lane u_lane (
      .lane      (lane_sel),
      .is_byte   (lane_byte),
      .is_write  (lane_write),
      .wdata     (lane_wdata_in),
      .rdata     (ram_rdata),
      .be_n      (lane_be_n),
      .wdata_rep (lane_wdata),
      .rdata_ext (lane_rdata)
   );

   always_comb begin
      state_next = state;
      start_mem  = 1'b0;
      start_if   = 1'b0;
      ram_ce_n   = 1'b1;
      ram_oe_n   = 1'b1;
      ram_we_n   = 1'b1;
      case (state)
         ST_IDLE: begin
            if (mem_elig) begin
               if (mem_misaligned) begin
                  state_next = ST_ERR;
               end else begin
                  start_mem  = 1'b1;
                  state_next = ST_ACCESS;
               end
            end else if (if_elig) begin
               start_if   = 1'b1;
               state_next = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            ram_ce_n = 1'b0;
            ram_oe_n = acc_we;
            // The final write cycle releases WE while data is still driven.
            ram_we_n = !(acc_we && (cnt != '0));
            if (cnt == '0) begin
               state_next = ST_IDLE;
            end
         end
         ST_ERR: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         sel_mem   <= 1'b0;
         acc_we    <= 1'b0;
         acc_byte  <= 1'b0;
         acc_lane  <= 2'b00;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_be_n  <= 4'hF;
         if_done   <= 1'b0;
         if_rdata  <= '0;
         mem_done  <= 1'b0;
         mem_err   <= 1'b0;
         mem_rdata <= '0;
      end else begin
         state    <= state_next;
         if_done  <= 1'b0;
         mem_done <= 1'b0;
         mem_err  <= 1'b0;
         if (start_mem) begin
            cnt       <= CNT_LOAD;
            sel_mem   <= 1'b1;
            acc_we    <= mem_we;
            acc_byte  <= mem_byte;
            acc_lane  <= mem_addr[1:0];
            ram_addr  <= mem_addr[ADDR_W+1:2];
            ram_wdata <= lane_wdata;
            ram_be_n  <= lane_be_n;
         end else if (start_if) begin
            cnt       <= CNT_LOAD;
            sel_mem   <= 1'b0;
            acc_we    <= 1'b0;
            acc_byte  <= 1'b0;
            acc_lane  <= LANE0;
            ram_addr  <= if_addr[ADDR_W+1:2];
            ram_be_n  <= 4'h0;
         end
         if (state == ST_ACCESS) begin
            if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end else if (sel_mem) begin
               mem_done <= 1'b1;
               if (!acc_we) begin
                  mem_rdata <= lane_rdata;
               end
            end else begin
               if_done  <= 1'b1;
               if_rdata <= ram_rdata;
            end
         end
         if (state == ST_ERR) begin
            mem_done <= 1'b1;
            mem_err  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard queue holds the expected
// completion of every request and is checked when a done pulse appears.
module tb_mem_arbiter;

   localparam int WAIT   = 2;
   localparam int ADDR_W = 20;

   typedef struct {
      logic        is_mem;
      logic [31:0] rdata;
      logic        err;
   } sb_entry_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req, mem_req, mem_we, mem_byte;
   logic [31:0]       if_addr, mem_addr, mem_wdata, ram_rdata;
   logic [31:0]       if_rdata, mem_rdata, ram_wdata;
   logic              if_done, mem_done, mem_err;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_ce_n, ram_oe_n, ram_we_n, busy;
   logic [3:0]        ram_be_n;

   sb_entry_t sb_q[$];
   int        n_cmp = 0;
   int        n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.WAIT_CYCLES(WAIT), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_byte  (mem_byte),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_done  (mem_done),
      .mem_err   (mem_err),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .ram_ce_n  (ram_ce_n),
      .ram_oe_n  (ram_oe_n),
      .ram_we_n  (ram_we_n),
      .ram_be_n  (ram_be_n),
      .busy      (busy)
   );

   // Inputs change and outputs are sampled on the falling edge, mid-cycle.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkDone(input string tag);
      sb_entry_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("[TB] FAIL %s: observed done with empty scoreboard, expected none", tag);
         return;
      end
      e = sb_q.pop_front();
      if (e.is_mem) begin
         checkOutput({tag, "_mem_done"}, 32'(mem_done), 32'd1);
         checkOutput({tag, "_if_done"}, 32'(if_done), 32'd0);
         checkOutput({tag, "_mem_rdata"}, mem_rdata, e.rdata);
         checkOutput({tag, "_mem_err"}, 32'(mem_err), 32'(e.err));
      end else begin
         checkOutput({tag, "_if_done"}, 32'(if_done), 32'd1);
         checkOutput({tag, "_mem_done"}, 32'(mem_done), 32'd0);
         checkOutput({tag, "_if_rdata"}, if_rdata, e.rdata);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic byt, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rd);
      mem_req   = 1'b1;
      mem_we    = we;
      mem_byte  = byt;
      mem_addr  = addr;
      mem_wdata = wdata;
      ram_rdata = rd;
   endtask

   // One complete MEM transaction from an idle cycle, checked for latency and result.
   task automatic doMem(input string tag, input logic we, input logic byt,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [31:0] exp_ram_addr, input int exp_lat);
      int lat;
      applyStimulus(we, byt, addr, wdata, rd);
      sb_q.push_back('{is_mem: 1'b1, rdata: exp_rdata, err: exp_err});
      step();
      checkOutput({tag, "_ce_n_c1"}, 32'(ram_ce_n), exp_err ? 32'd1 : 32'd0);
      if (!exp_err) checkOutput({tag, "_ram_addr"}, 32'(ram_addr), exp_ram_addr);
      lat = 1;
      while (!(mem_done || if_done) && lat < 20) begin
         step();
         lat++;
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      checkDone(tag);
      mem_req = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_byte = 1'b0;
      mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
      step();
      step();
      checkOutput("rst_ce_n", 32'(ram_ce_n), 32'd1);
      checkOutput("rst_oe_n", 32'(ram_oe_n), 32'd1);
      checkOutput("rst_we_n", 32'(ram_we_n), 32'd1);
      checkOutput("rst_be_n", 32'(ram_be_n), 32'hF);
      checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
      checkOutput("rst_ram_wdata", ram_wdata, 32'd0);
      checkOutput("rst_dones", 32'({if_done, mem_done, mem_err}), 32'd0);
      checkOutput("rst_rdata", if_rdata | mem_rdata, 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      step();

      $display("[TB] IF word read");
      if_req = 1'b1; if_addr = 32'h0000_0010; ram_rdata = 32'h1234_5678;
      sb_q.push_back('{is_mem: 1'b0, rdata: 32'h1234_5678, err: 1'b0});
      step();
      checkOutput("if_c1_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'b001);
      checkOutput("if_c1_addr", 32'(ram_addr), 32'h4);
      checkOutput("if_c1_busy", 32'(busy), 32'd1);
      checkOutput("if_c1_be_n", 32'(ram_be_n), 32'h0);
      step();
      checkOutput("if_c2_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'b001);
      checkOutput("if_c2_done", 32'(if_done), 32'd0);
      step();
      checkDone("if1");
      checkOutput("if_c3_busy", 32'(busy), 32'd0);
      checkOutput("if_c3_ce_n", 32'(ram_ce_n), 32'd1);
      if_req = 1'b0;
      step();

      $display("[TB] simultaneous IF and MEM requests");
      if_req = 1'b1; if_addr = 32'h0000_0020;
      applyStimulus(1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D);
      sb_q.push_back('{is_mem: 1'b1, rdata: 32'hCAFE_F00D, err: 1'b0});
      step();
      checkOutput("both_c1_addr", 32'(ram_addr), 32'h40);
      checkOutput("both_c1_oe_n", 32'(ram_oe_n), 32'd0);
      step();
      checkOutput("both_c2_ce_n", 32'(ram_ce_n), 32'd0);
      step();
      checkDone("both_mem");
      mem_req = 1'b0;
      ram_rdata = 32'h0BAD_BEEF;
      sb_q.push_back('{is_mem: 1'b0, rdata: 32'h0BAD_BEEF, err: 1'b0});
      step();
      checkOutput("both_c4_ce_n", 32'(ram_ce_n), 32'd0);
      checkOutput("both_c4_addr", 32'(ram_addr), 32'h8);
      step();
      checkOutput("both_c5_ce_n", 32'(ram_ce_n), 32'd0);
      checkOutput("both_c5_if_done", 32'(if_done), 32'd0);
      step();
      checkDone("both_if");
      if_req = 1'b0;
      step();

      $display("[TB] byte loads");
      doMem("lb103", 1'b0, 1'b1, 32'h103, 32'h0, 32'h80FF_0011, 32'hFFFF_FF80, 1'b0, 32'h40, WAIT + 1);
      doMem("lb101", 1'b0, 1'b1, 32'h101, 32'h0, 32'h80FF_0011, 32'h0000_0000, 1'b0, 32'h40, WAIT + 1);
      doMem("lb102", 1'b0, 1'b1, 32'h102, 32'h0, 32'h80FF_0011, 32'hFFFF_FFFF, 1'b0, 32'h40, WAIT + 1);
      doMem("lb100", 1'b0, 1'b1, 32'h100, 32'h0, 32'h80FF_0011, 32'h0000_0011, 1'b0, 32'h40, WAIT + 1);

      $display("[TB] byte store");
      applyStimulus(1'b1, 1'b1, 32'h102, 32'h0000_00AB, 32'h0);
      sb_q.push_back('{is_mem: 1'b1, rdata: 32'h0000_0011, err: 1'b0});
      step();
      checkOutput("sb_c1_wdata", ram_wdata, 32'hABAB_ABAB);
      checkOutput("sb_c1_be_n", 32'(ram_be_n), 32'b1011);
      checkOutput("sb_c1_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'b010);
      step();
      checkOutput("sb_c2_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'b011);
      checkOutput("sb_c2_be_n", 32'(ram_be_n), 32'b1011);
      checkOutput("sb_c2_wdata", ram_wdata, 32'hABAB_ABAB);
      step();
      checkDone("sb102");
      mem_req = 1'b0;
      step();

      $display("[TB] misaligned and aligned word stores");
      doMem("sw102", 1'b1, 1'b0, 32'h102, 32'hDEAD_BEEF, 32'h0, 32'h0000_0011, 1'b1, 32'h0, 2);
      doMem("sw104", 1'b1, 1'b0, 32'h104, 32'hDEAD_BEEF, 32'h0, 32'h0000_0011, 1'b0, 32'h41, WAIT + 1);
      checkOutput("sw104_wdata", ram_wdata, 32'hDEAD_BEEF);
      checkOutput("sw104_be_n", 32'(ram_be_n), 32'h0);
      doMem("lw_wrap", 1'b0, 1'b0, 32'hFFF0_0010, 32'h0, 32'h1357_2468, 32'h1357_2468, 1'b0, 32'hC0004, WAIT + 1);

      $display("[TB] reset during access");
      if_req = 1'b1; if_addr = 32'h0000_0040; ram_rdata = 32'h5A5A_5A5A;
      step();
      checkOutput("rstacc_c1_ce_n", 32'(ram_ce_n), 32'd0);
      rst = 1'b1;
      step();
      checkOutput("rstacc_c2_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'b111);
      checkOutput("rstacc_c2_if_done", 32'(if_done), 32'd0);
      rst = 1'b0;
      sb_q.push_back('{is_mem: 1'b0, rdata: 32'h5A5A_5A5A, err: 1'b0});
      n = 0;
      do begin
         step();
         n++;
      end while (!if_done && n < 20);
      checkOutput("rstacc_latency", 32'(n), 32'(WAIT + 1));
      checkDone("rstacc");
      if_req = 1'b0;
      step();
      checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
